// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Grant sources, default bus widths and the write-request record.
package wb_port_arbiter_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic Enabled  = 1'b1;
  localparam logic Disabled = 1'b0;

  localparam logic [RegAddrBus-1:0] NopRegAddr = '0;
  localparam logic [RegBus-1:0]     Zero       = '0;

  typedef struct packed {
    logic                  we;
    logic [RegAddrBus-1:0] rd;
    logic [RegBus-1:0]     data;
  } wb_req_t;

  // Who owns the write port in the current cycle.
  typedef enum logic [2:0] {
    GntNone,
    GntPipe,
    GntLu,
    GntDrop,
    GntBypass
  } wb_gnt_e;

endpackage

// File: rtl/wb_lu_fifo.sv
// DEPTH-entry queue of long-latency results with per-entry valid bits.
// A kill request invalidates every entry whose rd matches, in parallel.
module wb_lu_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_rd_i,
  output logic              head_valid_o,
  output logic [ADDR_W-1:0] head_rd_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic push_eff;
  logic pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;

  assign head_valid_o = !empty_o && valid_q[rd_ptr_q];
  assign head_rd_o    = rd_mem_q[rd_ptr_q];
  assign head_data_o  = data_mem_q[rd_ptr_q];

  // A push never targets the popped slot: push needs !full, pop needs !empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic kill_hit;
    assign kill_hit = kill_i && (rd_mem_q[gi] == kill_rd_i);
    assign valid_d[gi] =
        (push_eff && (wr_ptr_q == PTR_W'(gi))) ? 1'b1 :
        (pop_eff  && (rd_ptr_q == PTR_W'(gi))) ? 1'b0 :
        (valid_q[gi] && !kill_hit);
  end

  assign wr_ptr_d = wr_ptr_q + (push_eff ? PTR_W'(1) : PTR_W'(0));
  assign rd_ptr_d = rd_ptr_q + (pop_eff  ? PTR_W'(1) : PTR_W'(0));
  assign count_d  = count_q + (PTR_W+1)'(push_eff) - (PTR_W+1)'(pop_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the regfile write port between pipeline writeback and queued LU results.
// Optional macro WB_ARB_BYPASS_EN: an LU result skips the empty queue when the port is free.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = RegBus,
  parameter int ADDR_W       = RegAddrBus,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall_req
);

`ifdef WB_ARB_BYPASS_EN
  localparam logic BypassEn = Enabled;
`else
  localparam logic BypassEn = Disabled;
`endif

  localparam int             CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              stall_q, stall_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              fifo_push, fifo_pop;
  logic              fifo_empty, fifo_full;
  logic              head_valid;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  logic    pipe_wr;
  logic    lu_nonzero;
  wb_gnt_e gnt;

  assign pipe_wr    = pipe_we && (pipe_rd != ADDR_W'(NopRegAddr));
  assign lu_nonzero = lu_rd != ADDR_W'(NopRegAddr);
  assign lu_ready   = !fifo_full;

  always_comb begin
    gnt = GntNone;
    if (pipe_wr) begin
      gnt = GntPipe;
    end else if (!fifo_empty) begin
      gnt = head_valid ? GntLu : GntDrop;
    end else if (BypassEn && lu_valid && lu_nonzero) begin
      gnt = GntBypass;
    end
  end

  // A killed head is discarded even while the pipeline owns the port.
  assign fifo_pop  = (gnt == GntLu) || (!fifo_empty && !head_valid);
  assign fifo_push = lu_valid && lu_ready && lu_nonzero && (gnt != GntBypass);

  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (gnt)
      GntPipe: begin
        wb_we_d   = 1'b1;
        wb_rd_d   = pipe_rd;
        wb_data_d = pipe_data;
      end
      GntLu: begin
        wb_we_d   = 1'b1;
        wb_rd_d   = head_rd;
        wb_data_d = head_data;
      end
      GntBypass: begin
        wb_we_d   = 1'b1;
        wb_rd_d   = lu_rd;
        wb_data_d = lu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (head_valid && (gnt != GntLu)) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + CNT_W'(1);
    end
    stall_d = stall_q;
    if (starve_d == StarveMax) begin
      stall_d = Enabled;
    end else if ((gnt == GntLu) || fifo_empty) begin
      // Also drop on an empty queue so a fully killed backlog cannot freeze the pipe.
      stall_d = Disabled;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= ADDR_W'(NopRegAddr);
      wb_data_q <= DATA_W'(Zero);
      stall_q   <= Disabled;
      starve_q  <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      stall_q   <= stall_d;
      starve_q  <= starve_d;
    end
  end

  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign stall_req = stall_q;

  wb_lu_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fifo_push),
    .push_rd_i    (lu_rd),
    .push_data_i  (lu_data),
    .pop_i        (fifo_pop),
    .kill_i       (gnt == GntPipe),
    .kill_rd_i    (pipe_rd),
    .head_valid_o (head_valid),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand sequences
// and randomized traffic checked against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        pipe_we, lu_valid;
  logic [4:0]  pipe_rd, lu_rd;
  logic [31:0] pipe_data, lu_data;
  logic        lu_ready, wb_we, stall_req;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued LU results in age order, plus the visible outputs.
  typedef struct { logic v; logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic        m_we, m_stall;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_cnt;

  typedef struct {
    logic pw; logic [4:0] prd; logic [31:0] pd;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic e_ready; logic e_we; logic [4:0] e_rd; logic [31:0] e_data; logic e_stall;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_rd = '0; m_data = '0; m_stall = 1'b0; m_cnt = 0;
  endtask

  // One clock: drive inputs, check lu_ready before the edge, outputs after it.
  task automatic cycle(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       output logic rdy);
    int   sz;
    logic pipe_wr, hv, byp, ready, gnt_head;
    logic n_we, n_stall;
    logic [4:0]  n_rd;
    logic [31:0] n_data;
    int   n_cnt;
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    #1;
    rdy = lu_ready;
    sz       = mq.size();
    pipe_wr  = pw && (prd != 0);
    hv       = (sz > 0) && mq[0].v;
    ready    = (sz < DEPTH);
    gnt_head = !pipe_wr && hv;
    byp      = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    byp = (sz == 0) && !pipe_wr && lv && (lrd != 0);
`endif
    chk("lu_ready", lu_ready, ready);
    n_we = 1'b0; n_rd = m_rd; n_data = m_data;
    if (pipe_wr) begin n_we = 1'b1; n_rd = prd; n_data = pd; end
    else if (hv) begin n_we = 1'b1; n_rd = mq[0].rd; n_data = mq[0].data; end
    else if (byp) begin n_we = 1'b1; n_rd = lrd; n_data = ld; end
    n_cnt   = (hv && !gnt_head) ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
    n_stall = (n_cnt == LIMIT) ? 1'b1 : ((gnt_head || sz == 0) ? 1'b0 : m_stall);
    @(posedge clk);
    #1;
    if (pipe_wr)
      foreach (mq[i]) if (mq[i].v && mq[i].rd == prd) mq[i].v = 1'b0;
    if (sz > 0 && (gnt_head || !hv)) void'(mq.pop_front());
    if (ready && lv && lrd != 0 && !byp) mq.push_back('{1'b1, lrd, ld});
    m_we = n_we; m_rd = n_rd; m_data = n_data; m_cnt = n_cnt; m_stall = n_stall;
    chk("wb_we", wb_we, m_we);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_data", wb_data, m_data);
    chk("stall_req", stall_req, m_stall);
  endtask

  task automatic idle(output logic rdy);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_lu_ready", lu_ready, 1'b1);
  endtask

  initial begin
    logic r;
    vt[0]  = '{1, 1, 32'hA1, 1, 3, 32'h33, 1, 1, 1, 32'hA1, 0};
    vt[1]  = '{1, 2, 32'hA2, 1, 4, 32'h44, 1, 1, 2, 32'hA2, 0};
    vt[2]  = '{1, 1, 32'hA3, 1, 6, 32'h66, 0, 1, 1, 32'hA3, 0};
    vt[3]  = '{1, 2, 32'hA4, 1, 6, 32'h66, 0, 1, 2, 32'hA4, 0};
    vt[4]  = '{1, 1, 32'hA5, 1, 6, 32'h66, 0, 1, 1, 32'hA5, 1};
    vt[5]  = '{0, 0, 32'h0,  1, 6, 32'h66, 0, 1, 3, 32'h33, 0};
    vt[6]  = '{0, 0, 32'h0,  1, 6, 32'h66, 1, 1, 4, 32'h44, 0};
    vt[7]  = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 1, 6, 32'h66, 0};
    vt[8]  = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 6, 32'h66, 0};
    vt[9]  = '{1, 9, 32'h99, 1, 5, 32'h11, 1, 1, 9, 32'h99, 0};
    vt[10] = '{1, 5, 32'h22, 0, 0, 32'h0,  1, 1, 5, 32'h22, 0};
    vt[11] = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 5, 32'h22, 0};
    vt[12] = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 5, 32'h22, 0};
    vt[13] = '{1, 0, 32'hBAD, 1, 0, 32'h77, 1, 0, 5, 32'h22, 0};
    vt[14] = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 5, 32'h22, 0};

    rst = 1'b1;
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      idle(r);
      chk("idle_we", wb_we, 1'b0);
      chk("idle_stall", stall_req, 1'b0);
      chk("idle_ready", r, 1'b1);
    end
    $display("[TB] idle: 5 cycles, wb_we=%0b stall_req=%0b", wb_we, stall_req);

    // Bubble drain of a single LU result.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD, r);
    chk("drain_ready", r, 1'b1);
`ifdef WB_ARB_BYPASS_EN
    chk("drain_we", wb_we, 1'b1);
`else
    chk("drain_we_early", wb_we, 1'b0);
    idle(r);
    chk("drain_we", wb_we, 1'b1);
`endif
    chk("drain_rd", wb_rd, 5'd7);
    chk("drain_data", wb_data, 32'hDEAD);
    $display("[TB] drain: wb_we=%0b wb_rd=%0d wb_data=%0h", wb_we, wb_rd, wb_data);
    idle(r);

    // Priority, full, starvation, WAW kill and x0 vectors.
    for (int i = 0; i < 15; i++) begin
      cycle(vt[i].pw, vt[i].prd, vt[i].pd, vt[i].lv, vt[i].lrd, vt[i].ld, r);
      chk($sformatf("vec%0d_ready", i), r, vt[i].e_ready);
      chk($sformatf("vec%0d_we", i), wb_we, vt[i].e_we);
      chk($sformatf("vec%0d_rd", i), wb_rd, vt[i].e_rd);
      chk($sformatf("vec%0d_data", i), wb_data, vt[i].e_data);
      chk($sformatf("vec%0d_stall", i), stall_req, vt[i].e_stall);
      $display("[TB] vec %0d: pipe_we=%0b lu_valid=%0b -> ready=%0b wb_we=%0b wb_rd=%0d wb_data=%0h stall=%0b",
               i, vt[i].pw, vt[i].lv, r, wb_we, wb_rd, wb_data, stall_req);
    end

    // Reset with two entries queued: nothing stale may come out afterwards.
    cycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hAA, r);
    cycle(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'hBB, r);
    chk("pre_rst_full", lu_ready, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(r);
      chk("post_rst_we", wb_we, 1'b0);
    end
    $display("[TB] mid-reset: queue discarded, wb_we=%0b lu_ready=%0b", wb_we, lu_ready);

    // Randomized traffic, mostly honouring the stall contract.
    for (int i = 0; i < 600; i++) begin
      logic pw, lv;
      logic [4:0] prd, lrd;
      if (($urandom_range(0, 199)) == 0) begin
        do_reset();
        continue;
      end
      pw  = m_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0);
      prd = 5'($urandom_range(0, 7));
      lv  = ($urandom_range(0, 1) == 1);
      lrd = 5'($urandom_range(0, 7));
      cycle(pw, prd, $urandom, lv, lrd, $urandom, r);
    end
    $display("[TB] random: 600 cycles done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
